tuner_ctrl_seq: RTL and testbench
=================================

Name: tuner_ctrl_seq

Overview:
- Top-level sequencer for one ring tuner channel: global search → lock → track, through val/rdy handshakes with the search PHY and lock PHY.
- Converts the search result (peak code, peak power) into the lock PHY config: red-side start code and peak power.
- Supervises every wait phase with a timeout and a bounded retry count.
- Sits between the tuner CSR/host layer and the per-ring search/lock PHYs.

Parameters:
DAC_WIDTH, 8, ring tune code width
ADC_WIDTH, 8, power detector code width
TIMEOUT_WIDTH, 16, timeout counter width
MAX_RETRY, 3, failed attempts retried before ERROR

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_ctrl_start  in  1  level; start sequence from IDLE
i_ctrl_stop  in  1  level; request return to IDLE
i_cfg_red_offset  in  DAC_WIDTH  codes subtracted from search peak for lock start
i_cfg_pwr_min  in  ADC_WIDTH  minimum acceptable search peak power
i_cfg_timeout  in  TIMEOUT_WIDTH  wait-phase limit in cycles; 0 = disabled
o_search_trig_val  out  1  trigger search PHY
i_search_trig_rdy  in  1
i_search_done_val  in  1  search result valid
o_search_done_rdy  out  1
i_search_tune_peak  in  DAC_WIDTH  peak tune code
i_search_pwr_peak  in  ADC_WIDTH  peak power
o_lock_trig_val  out  1
i_lock_trig_rdy  in  1
i_lock_done_val  in  1
o_lock_done_rdy  out  1
o_lock_track_val  out  1  hold lock PHY in tracking
i_lock_track_rdy  in  1
i_lock_err  in  1  lock PHY lost-lock indication
o_cfg_ring_tune_start  out  DAC_WIDTH  to lock PHY
o_cfg_ring_pwr_peak  out  ADC_WIDTH  to lock PHY
o_locked  out  1  state == TRACK and track handshake seen
o_err  out  1  state == ERROR
o_state  out  3  current state encoding
o_retry_cnt  out  2  attempts consumed

Behaviour:
- Reset (async assert, sync deassert via i_rst_n):
  - state = IDLE; all val/rdy outputs 0; cfg regs 0.
  - retry_cnt = 0; timer = 0; stop_pend = 0; o_locked = 0.
- States: IDLE=0, SEARCH_TRIG=1, SEARCH_WAIT=2, LOCK_TRIG=3, LOCK_WAIT=4, TRACK=5, ERROR=6. All outputs are registered or decoded from the state register only.
- IDLE:
  - i_ctrl_start && !i_ctrl_stop → SEARCH_TRIG.
  - Entry into IDLE clears retry_cnt and stop_pend.
- SEARCH_TRIG:
  - o_search_trig_val=1, held until i_search_trig_rdy.
  - On fire → SEARCH_WAIT; timer cleared.
- SEARCH_WAIT:
  - o_search_done_rdy=1; timer increments each cycle.
  - On i_search_done_val: latch o_cfg_ring_pwr_peak = i_search_pwr_peak.
  - Latch o_cfg_ring_tune_start = i_search_tune_peak − i_cfg_red_offset, saturating at 0.
  - If pwr_peak < i_cfg_pwr_min → FAIL; else → LOCK_TRIG.
- LOCK_TRIG:
  - o_lock_trig_val=1 until i_lock_trig_rdy.
  - On fire → LOCK_WAIT; timer cleared.
- LOCK_WAIT:
  - o_lock_done_rdy=1; timer increments.
  - On i_lock_done_val → TRACK.
- TRACK:
  - o_lock_track_val=1 continuously.
  - o_locked set the cycle after val && i_lock_track_rdy; cleared on exit.
- ERROR: o_err=1; exits only to IDLE, via stop.
- Timeout:
  - In a WAIT state, when i_cfg_timeout≠0 and timer == i_cfg_timeout−1 without done → FAIL.
  - done_val in the same cycle as timeout wins; no FAIL.
  - Timer saturates and never wraps.
- FAIL:
  - If retry_cnt < MAX_RETRY: retry_cnt++ → SEARCH_TRIG.
  - Else → ERROR.
- Stop handling:
  - i_ctrl_stop sets stop_pend in any state.
  - stop_pend is acted on only in TRACK and ERROR: next state IDLE. TRACK deasserts o_lock_track_val the cycle IDLE is entered.
  - TRIG/WAIT handshakes always complete, so no val is ever withdrawn.
- i_ctrl_start outside IDLE is ignored.
- i_lock_err outside TRACK is ignored.
- Reset mid-handshake: all vals drop immediately; the PHYs are reset by the same reset domain.

Optional Feature:
Macro TUNER_CTRL_AUTO_RELOCK_EN.
- Defined: i_lock_err in TRACK (and no stop_pend) is treated as FAIL. o_lock_track_val drops and the retry path runs (new search). retry_cnt resets to 0 each time o_locked rises.
- Undefined: i_lock_err in TRACK → ERROR directly; retry_cnt untouched.

Decomposition:
- Package tuner_pkg holds:
  - tuner_ctrl_state_e (3-bit enum, encodings above).
  - Constant TUNER_CTRL_RETRY_W = 2.
- Sub-module tuner_ctrl_timer: saturating counter with clear, enable, limit input and timeout output. Instantiated once and shared by both WAIT states.

Test Plan:
- Nominal: start; search returns tune 100, pwr 200; offset 8; pwr_min 50 → tune_start 92, pwr_peak 200 → LOCK → TRACK, o_locked=1, o_retry_cnt=0.
- Saturation: tune peak 5, offset 8 → o_cfg_ring_tune_start = 0.
- Low power: three search results at pwr 10 with pwr_min 50 → three re-triggers, fourth failure → ERROR, o_err=1, o_retry_cnt=3; stop → IDLE, cnt 0.
- Timeout: i_cfg_timeout=20, lock_done never asserts → FAIL exactly 20 cycles after lock trig fire; done_val on cycle 20 → TRACK instead.
- Stop during SEARCH_WAIT: stop pulse, then search done → sequence continues to TRACK, then immediately IDLE with track_val dropped.
- i_lock_err in TRACK: with macro → new search_trig_val within 1 cycle; without → ERROR.

Source files
------------

// File: rtl/tuner_pkg.sv
// Shared types and constants for the tuner channel sequencer.
package tuner_pkg;

  // Encodings are visible on o_state, so keep them fixed.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SEARCH_TRIG = 3'd1,
    ST_SEARCH_WAIT = 3'd2,
    ST_LOCK_TRIG   = 3'd3,
    ST_LOCK_WAIT   = 3'd4,
    ST_TRACK       = 3'd5,
    ST_ERROR       = 3'd6
  } tuner_ctrl_state_e;

  localparam int TUNER_CTRL_RETRY_W = 2;

endpackage

// File: rtl/tuner_ctrl_timer.sv
// Saturating wait-phase timer with terminal-count compare.
// A limit of 0 disables the timeout output.
module tuner_ctrl_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             timeout
);

  logic [WIDTH-1:0] count;

  // Count up while enabled, hold at all-ones rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

  // Fires in the last allowed cycle so the FSM leaves exactly `limit` cycles after clear.
  assign timeout = en && (limit != '0) && (count == (limit - WIDTH'(1)));

endmodule

// File: rtl/tuner_ctrl_seq.sv
// Ring tuner channel sequencer: search -> lock -> track with timeout and retry.
// Optional build macro TUNER_CTRL_AUTO_RELOCK_EN: lost lock in TRACK re-runs the
// search through the retry path instead of going straight to ERROR.
//
// state       | meaning
// ------------+---------------------------------------------------
// IDLE        | waiting for start
// SEARCH_TRIG | offering trigger to search PHY
// SEARCH_WAIT | waiting for search result (timed)
// LOCK_TRIG   | offering trigger to lock PHY
// LOCK_WAIT   | waiting for lock done (timed)
// TRACK       | lock PHY held in tracking
// ERROR       | retries exhausted or lock lost; leave only via stop
module tuner_ctrl_seq
  import tuner_pkg::*;
#(
  parameter int DAC_WIDTH     = 8,
  parameter int ADC_WIDTH     = 8,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int MAX_RETRY     = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_ctrl_start,
  input  logic                          i_ctrl_stop,
  input  logic [DAC_WIDTH-1:0]          i_cfg_red_offset,
  input  logic [ADC_WIDTH-1:0]          i_cfg_pwr_min,
  input  logic [TIMEOUT_WIDTH-1:0]      i_cfg_timeout,
  output logic                          o_search_trig_val,
  input  logic                          i_search_trig_rdy,
  input  logic                          i_search_done_val,
  output logic                          o_search_done_rdy,
  input  logic [DAC_WIDTH-1:0]          i_search_tune_peak,
  input  logic [ADC_WIDTH-1:0]          i_search_pwr_peak,
  output logic                          o_lock_trig_val,
  input  logic                          i_lock_trig_rdy,
  input  logic                          i_lock_done_val,
  output logic                          o_lock_done_rdy,
  output logic                          o_lock_track_val,
  input  logic                          i_lock_track_rdy,
  input  logic                          i_lock_err,
  output logic [DAC_WIDTH-1:0]          o_cfg_ring_tune_start,
  output logic [ADC_WIDTH-1:0]          o_cfg_ring_pwr_peak,
  output logic                          o_locked,
  output logic                          o_err,
  output logic [2:0]                    o_state,
  output logic [TUNER_CTRL_RETRY_W-1:0] o_retry_cnt
);

  // MAX_RETRY must fit the retry counter width.
  localparam logic [TUNER_CTRL_RETRY_W-1:0] MAX_RETRY_C = TUNER_CTRL_RETRY_W'(MAX_RETRY);

  tuner_ctrl_state_e             state, next_state;
  logic [TUNER_CTRL_RETRY_W-1:0] retry_cnt;
  logic                          stop_pend;
  logic                          locked_q, locked_d;
  logic                          fail;
  logic                          srch_latch;
  logic                          in_wait;
  logic                          tmr_timeout;
  logic [DAC_WIDTH-1:0]          tune_start_d;
  logic [DAC_WIDTH-1:0]          tune_start_q;
  logic [ADC_WIDTH-1:0]          pwr_peak_q;

  assign in_wait = (state == ST_SEARCH_WAIT) || (state == ST_LOCK_WAIT);

  tuner_ctrl_timer #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (!in_wait),
    .en      (in_wait),
    .limit   (i_cfg_timeout),
    .timeout (tmr_timeout)
  );

  // Red-side start code, clamped at 0 instead of wrapping.
  assign tune_start_d = (i_search_tune_peak > i_cfg_red_offset) ?
                        (i_search_tune_peak - i_cfg_red_offset) : '0;

  // Next-state decode; done beats a same-cycle timeout.
  always_comb begin
    next_state = state;
    fail       = 1'b0;
    srch_latch = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_ctrl_start && !i_ctrl_stop) next_state = ST_SEARCH_TRIG;
      end
      ST_SEARCH_TRIG: begin
        if (i_search_trig_rdy) next_state = ST_SEARCH_WAIT;
      end
      ST_SEARCH_WAIT: begin
        if (i_search_done_val) begin
          srch_latch = 1'b1;
          if (i_search_pwr_peak < i_cfg_pwr_min) fail = 1'b1;
          else                                   next_state = ST_LOCK_TRIG;
        end else if (tmr_timeout) begin
          fail = 1'b1;
        end
      end
      ST_LOCK_TRIG: begin
        if (i_lock_trig_rdy) next_state = ST_LOCK_WAIT;
      end
      ST_LOCK_WAIT: begin
        if (i_lock_done_val)  next_state = ST_TRACK;
        else if (tmr_timeout) fail = 1'b1;
      end
      ST_TRACK: begin
        if (stop_pend) begin
          next_state = ST_IDLE;
        end else if (i_lock_err) begin
`ifdef TUNER_CTRL_AUTO_RELOCK_EN
          fail = 1'b1;
`else
          next_state = ST_ERROR;
`endif
        end
      end
      ST_ERROR: begin
        if (stop_pend) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (fail) begin
      next_state = (retry_cnt < MAX_RETRY_C) ? ST_SEARCH_TRIG : ST_ERROR;
    end
  end

  // Locked once the track handshake is seen, dropped on any exit from TRACK.
  assign locked_d = (state == ST_TRACK) && (next_state == ST_TRACK) &&
                    (locked_q || i_lock_track_rdy);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Retry accounting; cleared whenever IDLE is (re)entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      retry_cnt <= '0;
    end else if (next_state == ST_IDLE) begin
      retry_cnt <= '0;
    end else if (fail && (retry_cnt < MAX_RETRY_C)) begin
      retry_cnt <= retry_cnt + 1'b1;
`ifdef TUNER_CTRL_AUTO_RELOCK_EN
    end else if (locked_d && !locked_q) begin
      retry_cnt <= '0;
`endif
    end
  end

  // Stop is remembered until IDLE; held stop while idle does not leak into the next run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  stop_pend <= 1'b0;
    else if (next_state == ST_IDLE) stop_pend <= 1'b0;
    else if (i_ctrl_stop)          stop_pend <= 1'b1;
  end

  // Lock status flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) locked_q <= 1'b0;
    else          locked_q <= locked_d;
  end

  // Lock PHY config captured on the search result handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tune_start_q <= '0;
      pwr_peak_q   <= '0;
    end else if (srch_latch) begin
      tune_start_q <= tune_start_d;
      pwr_peak_q   <= i_search_pwr_peak;
    end
  end

  assign o_search_trig_val     = (state == ST_SEARCH_TRIG);
  assign o_search_done_rdy     = (state == ST_SEARCH_WAIT);
  assign o_lock_trig_val       = (state == ST_LOCK_TRIG);
  assign o_lock_done_rdy       = (state == ST_LOCK_WAIT);
  assign o_lock_track_val      = (state == ST_TRACK);
  assign o_err                 = (state == ST_ERROR);
  assign o_locked              = locked_q;
  assign o_state               = state;
  assign o_retry_cnt           = retry_cnt;
  assign o_cfg_ring_tune_start = tune_start_q;
  assign o_cfg_ring_pwr_peak   = pwr_peak_q;

endmodule

// File: tb/tb_tuner_ctrl_seq.sv
// Bench for tuner_ctrl_seq: scoreboard of expected lock PHY config, popped on lock trigger.
module tb_tuner_ctrl_seq;

  localparam logic [2:0] S_IDLE = 3'd0, S_STRIG = 3'd1, S_SWAIT = 3'd2,
                         S_LTRIG = 3'd3, S_LWAIT = 3'd4, S_TRACK = 3'd5, S_ERR = 3'd6;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_ctrl_start, i_ctrl_stop;
  logic [7:0]  i_cfg_red_offset, i_cfg_pwr_min;
  logic [15:0] i_cfg_timeout;
  logic        o_search_trig_val, i_search_trig_rdy, i_search_done_val, o_search_done_rdy;
  logic [7:0]  i_search_tune_peak, i_search_pwr_peak;
  logic        o_lock_trig_val, i_lock_trig_rdy, i_lock_done_val, o_lock_done_rdy;
  logic        o_lock_track_val, i_lock_track_rdy, i_lock_err;
  logic [7:0]  o_cfg_ring_tune_start, o_cfg_ring_pwr_peak;
  logic        o_locked, o_err;
  logic [2:0]  o_state;
  logic [1:0]  o_retry_cnt;

  typedef struct {
    logic [7:0] tune;
    logic [7:0] pwr;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  tuner_ctrl_seq dut (
    .i_clk                 (i_clk),
    .i_rst_n               (i_rst_n),
    .i_ctrl_start          (i_ctrl_start),
    .i_ctrl_stop           (i_ctrl_stop),
    .i_cfg_red_offset      (i_cfg_red_offset),
    .i_cfg_pwr_min         (i_cfg_pwr_min),
    .i_cfg_timeout         (i_cfg_timeout),
    .o_search_trig_val     (o_search_trig_val),
    .i_search_trig_rdy     (i_search_trig_rdy),
    .i_search_done_val     (i_search_done_val),
    .o_search_done_rdy     (o_search_done_rdy),
    .i_search_tune_peak    (i_search_tune_peak),
    .i_search_pwr_peak     (i_search_pwr_peak),
    .o_lock_trig_val       (o_lock_trig_val),
    .i_lock_trig_rdy       (i_lock_trig_rdy),
    .i_lock_done_val       (i_lock_done_val),
    .o_lock_done_rdy       (o_lock_done_rdy),
    .o_lock_track_val      (o_lock_track_val),
    .i_lock_track_rdy      (i_lock_track_rdy),
    .i_lock_err            (i_lock_err),
    .o_cfg_ring_tune_start (o_cfg_ring_tune_start),
    .o_cfg_ring_pwr_peak   (o_cfg_ring_pwr_peak),
    .o_locked              (o_locked),
    .o_err                 (o_err),
    .o_state               (o_state),
    .o_retry_cnt           (o_retry_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int n = 0; n < budget && o_state != s; n++) tick();
    check_eq(tag, {29'd0, o_state}, {29'd0, s});
  endtask

  // Drive one search result; the bench model predicts the lock config it should produce.
  task automatic search_done(input logic [7:0] tune, input logic [7:0] pwr);
    exp_t e;
    wait_state(S_SWAIT, 50, "reach_search_wait");
    i_search_done_val  = 1'b1;
    i_search_tune_peak = tune;
    i_search_pwr_peak  = pwr;
    if (pwr >= i_cfg_pwr_min) begin
      e.tune = (tune > i_cfg_red_offset) ? tune - i_cfg_red_offset : 8'd0;
      e.pwr  = pwr;
      exp_q.push_back(e);
    end
    tick();
    i_search_done_val = 1'b0;
  endtask

  task automatic lock_done();
    wait_state(S_LWAIT, 50, "reach_lock_wait");
    i_lock_done_val = 1'b1;
    tick();
    i_lock_done_val = 1'b0;
  endtask

  task automatic start_pulse();
    i_ctrl_start = 1'b1;
    tick();
    i_ctrl_start = 1'b0;
  endtask

  task automatic stop_pulse();
    i_ctrl_stop = 1'b1;
    tick();
    i_ctrl_stop = 1'b0;
  endtask

  // Scoreboard consumer: lock config must be valid when the lock trigger fires.
  always @(negedge i_clk) begin
    if (i_rst_n && o_lock_trig_val && i_lock_trig_rdy) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_lock_trig", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sb_tune_start", {24'd0, o_cfg_ring_tune_start}, {24'd0, e.tune});
        check_eq("sb_pwr_peak",   {24'd0, o_cfg_ring_pwr_peak},   {24'd0, e.pwr});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    i_rst_n = 1'b0;
    i_ctrl_start = 0; i_ctrl_stop = 0;
    i_cfg_red_offset = 8'd8; i_cfg_pwr_min = 8'd50; i_cfg_timeout = 16'd0;
    i_search_trig_rdy = 0; i_search_done_val = 0;
    i_search_tune_peak = 0; i_search_pwr_peak = 0;
    i_lock_trig_rdy = 1; i_lock_done_val = 0; i_lock_track_rdy = 1; i_lock_err = 0;
    repeat (3) tick();

    check_eq("rst_state",      {29'd0, o_state}, {29'd0, S_IDLE});
    check_eq("rst_vals",       {28'd0, o_search_trig_val, o_lock_trig_val, o_lock_track_val, o_search_done_rdy}, 32'd0);
    check_eq("rst_locked_err", {30'd0, o_locked, o_err}, 32'd0);
    check_eq("rst_retry",      {30'd0, o_retry_cnt}, 32'd0);
    check_eq("rst_cfg",        {16'd0, o_cfg_ring_tune_start, o_cfg_ring_pwr_peak}, 32'd0);
    i_rst_n = 1'b1;
    tick();

    // Nominal, with the search trigger held off for a few cycles.
    start_pulse();
    repeat (3) tick();
    check_eq("trig_held_state", {29'd0, o_state}, {29'd0, S_STRIG});
    check_eq("trig_held_val",   {31'd0, o_search_trig_val}, 32'd1);
    i_search_trig_rdy = 1'b1;
    search_done(8'd100, 8'd200);
    lock_done();
    check_eq("nom_track", {29'd0, o_state}, {29'd0, S_TRACK});
    tick();
    check_eq("nom_locked",    {31'd0, o_locked}, 32'd1);
    check_eq("nom_retry",     {30'd0, o_retry_cnt}, 32'd0);
    check_eq("nom_tune",      {24'd0, o_cfg_ring_tune_start}, 32'd92);
    check_eq("nom_track_val", {31'd0, o_lock_track_val}, 32'd1);
    stop_pulse();
    wait_state(S_IDLE, 10, "nom_stop_idle");
    check_eq("nom_idle_track_val", {31'd0, o_lock_track_val}, 32'd0);
    check_eq("nom_idle_locked",    {31'd0, o_locked}, 32'd0);

    // Start code saturation.
    start_pulse();
    search_done(8'd5, 8'd200);
    lock_done();
    check_eq("sat_tune", {24'd0, o_cfg_ring_tune_start}, 32'd0);
    stop_pulse();
    wait_state(S_IDLE, 10, "sat_stop_idle");

    // Low power: three retries then ERROR.
    start_pulse();
    for (int k = 1; k <= 3; k++) begin
      search_done(8'd10, 8'd10);
      check_eq("lowpwr_retrig", {29'd0, o_state}, {29'd0, S_STRIG});
      check_eq("lowpwr_retry",  {30'd0, o_retry_cnt}, k);
    end
    search_done(8'd10, 8'd10);
    check_eq("lowpwr_err_state", {29'd0, o_state}, {29'd0, S_ERR});
    check_eq("lowpwr_err",       {31'd0, o_err}, 32'd1);
    check_eq("lowpwr_retry3",    {30'd0, o_retry_cnt}, 32'd3);
    check_eq("lowpwr_cfg",       {16'd0, o_cfg_ring_tune_start, o_cfg_ring_pwr_peak}, {16'd0, 8'd2, 8'd10});
    start_pulse();
    tick();
    check_eq("err_ignores_start", {29'd0, o_state}, {29'd0, S_ERR});
    stop_pulse();
    wait_state(S_IDLE, 10, "err_stop_idle");
    check_eq("err_idle_retry", {30'd0, o_retry_cnt}, 32'd0);
    check_eq("err_idle_err",   {31'd0, o_err}, 32'd0);

    // Lock timeout of 20 cycles, then done on the last allowed cycle.
    i_cfg_timeout = 16'd20;
    start_pulse();
    search_done(8'd100, 8'd200);
    wait_state(S_LWAIT, 10, "to_reach_lwait");
    n = 0;
    while (o_state == S_LWAIT && n < 100) begin
      tick();
      n++;
    end
    check_eq("to_cycles",  n, 32'd20);
    check_eq("to_retrig",  {29'd0, o_state}, {29'd0, S_STRIG});
    check_eq("to_retry",   {30'd0, o_retry_cnt}, 32'd1);
    search_done(8'd100, 8'd200);
    wait_state(S_LWAIT, 10, "to2_reach_lwait");
    repeat (19) tick();
    check_eq("to2_still_wait", {29'd0, o_state}, {29'd0, S_LWAIT});
    i_lock_done_val = 1'b1;
    tick();
    i_lock_done_val = 1'b0;
    check_eq("to2_done_wins", {29'd0, o_state}, {29'd0, S_TRACK});
    tick();
`ifdef TUNER_CTRL_AUTO_RELOCK_EN
    check_eq("to2_retry", {30'd0, o_retry_cnt}, 32'd0);
`else
    check_eq("to2_retry", {30'd0, o_retry_cnt}, 32'd1);
`endif
    stop_pulse();
    wait_state(S_IDLE, 10, "to2_stop_idle");
    i_cfg_timeout = 16'd0;

    // Stop during SEARCH_WAIT: handshakes complete, then one TRACK cycle.
    start_pulse();
    wait_state(S_SWAIT, 10, "stopw_reach_swait");
    stop_pulse();
    search_done(8'd120, 8'd150);
    lock_done();
    check_eq("stopw_track",     {29'd0, o_state}, {29'd0, S_TRACK});
    check_eq("stopw_track_val", {31'd0, o_lock_track_val}, 32'd1);
    tick();
    check_eq("stopw_idle",      {29'd0, o_state}, {29'd0, S_IDLE});
    check_eq("stopw_val_drop",  {31'd0, o_lock_track_val}, 32'd0);
    check_eq("stopw_locked",    {31'd0, o_locked}, 32'd0);

    // Lost lock while tracking.
    start_pulse();
    search_done(8'd60, 8'd100);
    lock_done();
    tick();
    check_eq("lerr_locked", {31'd0, o_locked}, 32'd1);
    i_lock_err = 1'b1;
    tick();
    i_lock_err = 1'b0;
`ifdef TUNER_CTRL_AUTO_RELOCK_EN
    check_eq("lerr_state",     {29'd0, o_state}, {29'd0, S_STRIG});
    check_eq("lerr_trig_val",  {31'd0, o_search_trig_val}, 32'd1);
    check_eq("lerr_retry",     {30'd0, o_retry_cnt}, 32'd1);
`else
    check_eq("lerr_state",     {29'd0, o_state}, {29'd0, S_ERR});
    check_eq("lerr_err",       {31'd0, o_err}, 32'd1);
    check_eq("lerr_retry",     {30'd0, o_retry_cnt}, 32'd0);
`endif
    check_eq("lerr_track_val", {31'd0, o_lock_track_val}, 32'd0);
    check_eq("lerr_locked_clr",{31'd0, o_locked}, 32'd0);

    // Asynchronous reset acts without a clock edge.
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("async_rst_state", {29'd0, o_state}, {29'd0, S_IDLE});
    check_eq("async_rst_vals",  {29'd0, o_search_trig_val, o_lock_trig_val, o_err}, 32'd0);

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
